// File: rtl/sjr_run_controller_pkg.sv
// rtl/sjr_run_controller_pkg.sv - shared state encoding and widths for the run controller
package sjr_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  // State codes kept as 32-bit parameters so existing tooling that greps them keeps working
  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_RST  = 32'd1;
  localparam logic [31:0] ST_REQ  = 32'd2;
  localparam logic [31:0] ST_RUN  = 32'd3;
  localparam logic [31:0] ST_DONE = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'(ST_IDLE),
    S_RST  = 3'(ST_RST),
    S_REQ  = 3'(ST_REQ),
    S_RUN  = 3'(ST_RUN),
    S_DONE = 3'(ST_DONE)
  } state_e;

endpackage

// File: rtl/sjr_run_controller_if.sv
// rtl/sjr_run_controller_if.sv - host/target handshake bundle of the run controller
interface sjr_run_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             go;
  logic             target_reset;
  logic             run_req;
  logic             run_busy;
  logic             finish_flag;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  go, run_busy, finish_flag,
    output target_reset, run_req, busy, done, timed_out, cycle_count
  );

  modport slave (
    output go, run_busy, finish_flag,
    input  target_reset, run_req, busy, done, timed_out, cycle_count
  );
endinterface

// File: rtl/sjr_run_controller_sat_counter.sv
// rtl/sjr_run_controller_sat_counter.sv - saturating up-counter with clear and enable
module sjr_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o
);

  logic [CNT_W-1:0] count_q;

  // Value the counter takes when enabled; sticks at all-ones instead of wrapping
  always_comb begin
    count_next_o = (&count_q) ? count_q : count_q + CNT_W'(1);
  end

  // Clear has priority so a new run always starts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_next_o;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sjr_run_controller.sv
// rtl/sjr_run_controller.sv - resets a target, issues its run handshake, times and latches the result
module sjr_run_controller
  import sjr_ctrl_pkg::*;
#(
  parameter int unsigned      RESET_CYCLES = 4,
  parameter int unsigned      CNT_W        = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] TIMEOUT      = '1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  sjr_run_controller_if.master bus
);

  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic             target_reset_q, target_reset_d;
  logic             run_req_q, run_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic             cnt_clr, cnt_en, timeout_hit;
  logic [CNT_W-1:0] cnt_q, cnt_inc;

  sjr_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .count_o     (cnt_q),
    .count_next_o(cnt_inc)
  );

  // Timeout looks at the value this cycle will be counted to, so DONE lands exactly on TIMEOUT
  assign timeout_hit = (TIMEOUT != '0) && (cnt_inc >= TIMEOUT);

  // Next state and next registered outputs; completion is tested before timeout so it wins ties
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    timed_out_d = timed_out_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          state_d     = S_RST;
          rst_cnt_d   = 8'd0;
          timed_out_d = 1'b0;
          cnt_clr     = 1'b1;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = S_REQ;
        else                       rst_cnt_d = rst_cnt_q + 8'd1;
      end
      S_REQ: begin
        cnt_en = 1'b1;
        if (bus.finish_flag) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else if (bus.run_busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (bus.finish_flag || !bus.run_busy) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    target_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
    run_req_d      = (state_d == S_REQ);
    busy_d         = (state_d == S_RST) || (state_d == S_REQ) || (state_d == S_RUN);
    done_d         = (state_d == S_DONE);
  end

  // State and output registers; reset holds the target in reset while idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= 8'd0;
      target_reset_q <= 1'b1;
      run_req_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      target_reset_q <= target_reset_d;
      run_req_q      <= run_req_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timed_out_q    <= timed_out_d;
    end
  end

  assign bus.target_reset = target_reset_q;
  assign bus.run_req      = run_req_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timed_out    = timed_out_q;
  assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_sjr_run_controller.sv
// tb/tb_sjr_run_controller.sv - randomized self-checking bench for sjr_run_controller
module tb_sjr_run_controller;

  localparam int          R   = 4;
  localparam int          W   = 32;
  localparam logic [31:0] TMO = 32'd50;
  localparam longint      MAXC = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sjr_run_controller_if #(.CNT_W(W)) bus ();

  sjr_run_controller #(.RESET_CYCLES(R), .CNT_W(W), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is the go edge plus a count of post-reset cycles
  bit     m_run, m_done, m_busy_seen, m_timed;
  longint m_go_edge, m_count;
  longint edge_no = 0;

  function automatic void m_reset();
    m_run = 0; m_done = 0; m_busy_seen = 0; m_timed = 0;
    m_go_edge = 0; m_count = 0;
  endfunction

  function automatic void m_step(bit go, bit rb, bit ff);
    if (!m_run) begin
      if (go) begin
        m_run = 1; m_done = 0; m_busy_seen = 0; m_timed = 0;
        m_go_edge = edge_no; m_count = 0;
      end
    end else if (edge_no - m_go_edge > R) begin
      if (m_count < MAXC) m_count = m_count + 1;
      if (ff || (m_busy_seen && !rb)) begin
        m_run = 0; m_done = 1;
      end else if (TMO != 0 && m_count >= TMO) begin
        m_run = 0; m_done = 1; m_timed = 1;
      end else if (rb) begin
        m_busy_seen = 1;
      end
    end
  endfunction

  initial m_reset();
  always @(negedge rst_n) m_reset();

  // Advance the model on each edge and compare every output shortly after
  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) m_reset();
    else m_step(bus.go, bus.run_busy, bus.finish_flag);
    #2;
    if (rst_n) begin
      chk("target_reset", bus.target_reset,
          m_run ? (edge_no - m_go_edge < R) : !m_done);
      chk("run_req", bus.run_req, m_run && (edge_no - m_go_edge >= R) && !m_busy_seen);
      chk("busy", bus.busy, m_run);
      chk("done", bus.done, !m_run && m_done);
      chk("timed_out", bus.timed_out, m_timed);
      chk("cycle_count", bus.cycle_count, m_count);
    end
  end

  // Target model: t counts cycles from the first run_req cycle; negative knobs mean "never"
  task automatic run_once(input int bdel, input int blen, input int fcyc, input int gocyc,
                          output longint cnt, output bit tmo, output int rq_n, output int tr_lat);
    bit st;
    int t;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    st = 0; t = 0; rq_n = 0; tr_lat = -1; cnt = -1; tmo = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (tr_lat < 0 && !bus.target_reset) tr_lat = n + 1;
      if (bus.run_req) rq_n++;
      if (bus.done) begin
        cnt = longint'(bus.cycle_count);
        tmo = bus.timed_out;
        break;
      end
      if (!st && bus.run_req) begin st = 1; t = 0; end
      else if (st) t++;
      bus.run_busy    = st && bdel >= 0 && t >= bdel && (blen == 0 || t < bdel + blen);
      bus.finish_flag = st && fcyc >= 0 && t == fcyc;
      bus.go          = st && gocyc >= 0 && t == gocyc;
    end
    bus.run_busy = 1'b0; bus.finish_flag = 1'b0; bus.go = 1'b0;
    if (cnt < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_done: done never seen within budget, expected done=1");
    end
  endtask

  longint cnt;
  bit     tmo;
  int     rq_n, tr_lat;

  initial begin
    bus.go = 1'b0; bus.run_busy = 1'b0; bus.finish_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_target_reset", bus.target_reset, 1);
    chk("rst_run_req", bus.run_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timed_out", bus.timed_out, 0);
    chk("rst_cycle_count", bus.cycle_count, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_once(0, 0, 10, -1, cnt, tmo, rq_n, tr_lat);
    chk("basic_count", cnt, 11);
    chk("basic_timed_out", tmo, 0);
    chk("basic_run_req_cycles", rq_n, 1);
    chk("basic_tr_fall_at_T+", tr_lat, R + 1);

    run_once(0, 20, -1, -1, cnt, tmo, rq_n, tr_lat);
    chk("busyfall_count", cnt, 21);
    chk("busyfall_timed_out", tmo, 0);

    run_once(-1, 0, -1, -1, cnt, tmo, rq_n, tr_lat);
    chk("timeout_count", cnt, 50);
    chk("timeout_timed_out", tmo, 1);
    chk("timeout_run_req_cycles", rq_n, 50);

    run_once(0, 0, 10, 3, cnt, tmo, rq_n, tr_lat);
    chk("rerun_count", cnt, 11);
    chk("rerun_timed_out", tmo, 0);
    chk("rerun_run_req_cycles", rq_n, 1);

    run_once(0, 0, 49, -1, cnt, tmo, rq_n, tr_lat);
    chk("simul_count", cnt, 50);
    chk("simul_timed_out", tmo, 0);

    run_once(3, 0, 2, -1, cnt, tmo, rq_n, tr_lat);
    chk("reqfinish_count", cnt, 3);
    chk("reqfinish_timed_out", tmo, 0);

    // Abort a run part-way through RUN with an async reset between clock edges
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.run_busy = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_target_reset", bus.target_reset, 1);
    chk("async_run_req", bus.run_req, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_done", bus.done, 0);
    chk("async_cycle_count", bus.cycle_count, 0);
    bus.run_busy = 1'b0;
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_once(0, 0, 10, -1, cnt, tmo, rq_n, tr_lat);
    chk("post_reset_count", cnt, 11);

    for (int i = 0; i < 25; i++) begin
      int bdel, blen, fcyc, gocyc;
      bdel  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      blen  = int'($urandom_range(0, 40));
      fcyc  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60));
      gocyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_once(bdel, blen, fcyc, gocyc, cnt, tmo, rq_n, tr_lat);
    end

    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
